ifu_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the decoder and legality checker.
- Owns the PC register and issues one 32-bit instruction request at a time to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Presents each fetched instruction, its PC and its pre-split opcode/funct3/funct7 fields to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/trap/mret) from execute and discards stale in-flight fetches.

---
 rtl/ifu_fetch.sv | 103 ++++++++++
 tb/tb_ifu_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch stage with PC ownership, redirect/kill and decode handshake
module ifu_fetch #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            inst_fault
);
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;
  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;
  logic            r_kill;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_fault;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_boot_pc;
  logic [XLEN-1:0] w_hold_pc;
  logic [XLEN-1:0] w_wait_pc;
  assign w_tgt          = redirect_pc & ~XLEN'(3);
  assign w_boot_pc      = redirect_valid ? w_tgt : r_pc;
  assign w_hold_pc      = redirect_valid ? w_tgt : r_inst_pc + XLEN'(4);
  assign w_wait_pc      = redirect_valid ? w_tgt : r_pc;
  assign imem_req_valid = r_state == REQ;
  assign imem_req_addr  = r_req_addr;
  assign inst_valid     = r_state == HOLD;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign inst_fault     = r_fault;
  assign opcode         = r_inst[6:0];
  assign funct3         = r_inst[14:12];
  assign funct7         = r_inst[31:25];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_kill     <= 1'b0;
      r_inst     <= 32'h0;
      r_inst_pc  <= RESET_PC;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_pc       <= w_boot_pc;
          r_req_addr <= w_boot_pc;
          r_state    <= REQ;
        end
        REQ: begin
          if (redirect_valid) begin
            r_pc   <= w_tgt;
            r_kill <= 1'b1;
          end
          if (imem_req_ready) r_state <= WAIT;
        end
        WAIT: begin
          // a same-cycle redirect or a pending kill both turn the response into a refetch
          if (imem_resp_valid && (redirect_valid || r_kill)) begin
            r_kill     <= 1'b0;
            r_pc       <= w_wait_pc;
            r_req_addr <= w_wait_pc;
            r_state    <= REQ;
          end else if (imem_resp_valid) begin
            r_inst    <= imem_resp_err ? 32'h0 : imem_resp_data;
            r_inst_pc <= r_req_addr;
            r_fault   <= imem_resp_err;
            r_state   <= HOLD;
          end else if (redirect_valid) begin
            r_pc   <= w_tgt;
            r_kill <= 1'b1;
          end
        end
        default: begin
          if (redirect_valid || inst_ready) begin
            r_pc       <= w_hold_pc;
            r_req_addr <= w_hold_pc;
            r_state    <= REQ;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed and randomized checks of ifu_fetch against a transaction-level fetch model
module tb_ifu_fetch;
  localparam logic [63:0] RST = 64'h8000_0000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_resp_err = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        inst_fault;

  ifu_fetch #(.XLEN(64), .RESET_PC(RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  // memory environment knobs and in-flight response
  bit          rdy_rand = 0, lat_rand = 0, err_rand = 0, spur_en = 0, err_next = 0, ovr_en = 0;
  int          lat = 1;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = 64'h0;
  logic        mem_err = 1'b0;
  logic [31:0] ovr = 32'h0;
  // fetch model: what the stage is doing in terms of transactions
  bit          m_boot, m_req, m_wait, m_stale, m_hold, m_fault;
  logic [63:0] m_pc, m_addr, m_ipc;
  logic [31:0] m_inst;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  task automatic model_reset();
    m_boot = 1; m_req = 0; m_wait = 0; m_stale = 0; m_hold = 0; m_fault = 0;
    m_pc = RST; m_addr = RST; m_ipc = RST; m_inst = 32'h0;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check();
    chk("req_valid", 64'(imem_req_valid), 64'(m_req));
    if (m_req) chk("req_addr", imem_req_addr, m_addr);
    chk("inst_valid", 64'(inst_valid), 64'(m_hold));
    chk("inst", 64'(inst), 64'(m_inst));
    chk("inst_pc", inst_pc, m_ipc);
    chk("inst_fault", 64'(inst_fault), 64'(m_fault));
    chk("opcode", 64'(opcode), 64'(m_inst[6:0]));
    chk("funct3", 64'(funct3), 64'(m_inst[14:12]));
    chk("funct7", 64'(funct7), 64'(m_inst[31:25]));
  endtask

  // called at a negedge: drive one cycle of inputs, advance the model, check at the next negedge
  task automatic step(input logic rv, input logic [63:0] tgt, input logic ir);
    logic        rsp, rdy, er;
    logic [31:0] d;
    logic [63:0] t;
    rsp = 0; er = 0; d = $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rsp = 1; er = mem_err;
        d = ovr_en ? ovr : mem_word(mem_addr);
        ovr_en = 0;
      end
    end else if (spur_en && !m_wait && $urandom_range(0, 5) == 0) begin
      rsp = 1; er = 1'($urandom_range(0, 1));
    end
    rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (imem_req_valid && rdy) begin
      mem_cnt  = lat_rand ? $urandom_range(1, 4) : lat;
      mem_addr = imem_req_addr;
      mem_err  = err_rand ? ($urandom_range(0, 7) == 0) : err_next;
    end
    imem_req_ready = rdy; imem_resp_valid = rsp; imem_resp_data = d; imem_resp_err = er;
    redirect_valid = rv; redirect_pc = tgt; inst_ready = ir;
    t = tgt & ~64'h3;
    if (m_boot) begin
      m_boot = 0;
      if (rv) m_pc = t;
      m_addr = m_pc; m_req = 1;
    end else if (m_req) begin
      if (rv) begin m_pc = t; m_stale = 1; end
      if (rdy) begin m_req = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (rsp) begin
        m_wait = 0;
        if (rv) begin m_pc = t; m_addr = t; m_stale = 0; m_req = 1; end
        else if (m_stale) begin m_stale = 0; m_addr = m_pc; m_req = 1; end
        else begin m_hold = 1; m_inst = er ? 32'h0 : d; m_ipc = m_addr; m_fault = er; end
      end else if (rv) begin m_pc = t; m_stale = 1; end
    end else if (m_hold && (rv || ir)) begin
      m_hold = 0; m_pc = rv ? t : m_ipc + 64'd4; m_addr = m_pc; m_req = 1;
    end
    @(negedge clk);
    check();
  endtask

  task automatic do_reset(input logic late);
    #2 rst_n = 0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_inst_valid", 64'(inst_valid), 64'h0);
    chk("rst_inst", 64'(inst), 64'h0);
    chk("rst_inst_pc", inst_pc, RST);
    chk("rst_fault", 64'(inst_fault), 64'h0);
    chk("rst_opcode", 64'(opcode), 64'h0);
    redirect_valid = 0; imem_resp_valid = late; imem_resp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_resp_valid = 0; rst_n = 1; mem_cnt = 0;
    model_reset();
    check();
  endtask

  initial begin
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("por_req_valid", 64'(imem_req_valid), 64'h0);
    chk("por_inst_pc", inst_pc, RST);
    check();
    rst_n = 1;
    // straight-line fetch with an always-ready, 1-cycle memory
    ovr_en = 1; ovr = 32'h0010_0073;
    step(0, 0, 1);
    chk("t1_addr0", imem_req_addr, 64'h8000_0000);
    step(0, 0, 1); step(0, 0, 1);
    chk("t1_inst", 64'(inst), 64'h0010_0073);
    chk("t1_opcode", 64'(opcode), 64'h73);
    chk("t1_funct3", 64'(funct3), 64'h0);
    chk("t1_funct7", 64'(funct7), 64'h0);
    chk("t1_pc0", inst_pc, 64'h8000_0000);
    step(0, 0, 1);
    chk("t1_addr1", imem_req_addr, 64'h8000_0004);
    step(0, 0, 1); step(0, 0, 1);
    chk("t1_pc1", inst_pc, 64'h8000_0004);
    chk("t1_word1", 64'(inst), 64'(mem_word(64'h8000_0004)));
    step(0, 0, 1);
    chk("t1_addr2", imem_req_addr, 64'h8000_0008);
    // decode backpressure
    step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      chk("t2_valid", 64'(inst_valid), 64'h1);
      chk("t2_pc", inst_pc, 64'h8000_0008);
      chk("t2_noreq", 64'(imem_req_valid), 64'h0);
    end
    step(0, 0, 1);
    chk("t2_addr", imem_req_addr, 64'h8000_000C);
    // redirect while waiting, response 3 cycles after handshake
    lat = 3;
    step(0, 0, 0);
    step(1, 64'h8000_0101, 0);
    chk("t3_nov0", 64'(inst_valid), 64'h0);
    step(0, 0, 0);
    chk("t3_nov1", 64'(inst_valid), 64'h0);
    step(0, 0, 0);
    chk("t3_nov2", 64'(inst_valid), 64'h0);
    chk("t3_req", 64'(imem_req_valid), 64'h1);
    chk("t3_addr", imem_req_addr, 64'h8000_0100);
    // redirect beats same-cycle decode handshake
    lat = 1;
    step(0, 0, 0); step(0, 0, 0);
    chk("t4_pc", inst_pc, 64'h8000_0100);
    step(1, 64'h8000_0200, 1);
    chk("t4_drop", 64'(inst_valid), 64'h0);
    chk("t4_addr", imem_req_addr, 64'h8000_0200);
    // access fault
    step(0, 0, 0); step(0, 0, 0);
    step(1, 64'h8000_0010, 0);
    err_next = 1;
    step(0, 0, 0); step(0, 0, 0);
    err_next = 0;
    chk("t5_valid", 64'(inst_valid), 64'h1);
    chk("t5_fault", 64'(inst_fault), 64'h1);
    chk("t5_inst", 64'(inst), 64'h0);
    chk("t5_pc", inst_pc, 64'h8000_0010);
    step(0, 0, 1);
    chk("t5_next", imem_req_addr, 64'h8000_0014);
    // async reset mid-wait with a late response
    lat = 3;
    step(0, 0, 0);
    do_reset(1);
    step(0, 0, 1);
    chk("t6_addr", imem_req_addr, RST);
    chk("t6_valid", 64'(imem_req_valid), 64'h1);
    // redirect during the boot cycle
    do_reset(0);
    step(1, 64'h0000_0000_0012_3457, 1);
    chk("t7_addr", imem_req_addr, 64'h0000_0000_0012_3454);
    // wrap of pc+4
    lat = 1;
    step(0, 0, 0); step(0, 0, 0);
    step(1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    chk("t8_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 1);
    chk("t8_wrap", imem_req_addr, 64'h0);
    // randomized traffic
    rdy_rand = 1; lat_rand = 1; err_rand = 1; spur_en = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset(1'($urandom_range(0, 1)));
      else begin
        logic [63:0] tg;
        case ($urandom_range(0, 3))
          0: tg = {$urandom, $urandom};
          1: tg = 64'hFFFF_FFFF_FFFF_FFFC;
          default: tg = RST + 64'($urandom_range(0, 255));
        endcase
        step($urandom_range(0, 9) == 0, tg, $urandom_range(0, 4) < 3);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
